// File: rtl/pwm_pkg.sv
// Shared types and default sizing for the multichannel PWM block.
package pwm_pkg;

  typedef enum logic {
    PWM_EDGE   = 1'b0,
    PWM_CENTER = 1'b1
  } pwm_mode_e;

  localparam int NCH_DEF     = 4;
  localparam int WIDTH_DEF   = 8;
  localparam int PRESC_W_DEF = 4;

endpackage

// File: rtl/pwm_chan.sv
// One PWM channel: shadow and active duty registers, compare against the
// shared counter, and the registered output.
module pwm_chan
  import pwm_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             load,
  input  logic             xfer,
  input  logic [WIDTH-1:0] duty,
  input  logic [WIDTH-1:0] cnt,
  output logic             pwm_out
);

  logic [WIDTH-1:0] r_duty_s;
  logic [WIDTH-1:0] r_duty_a;
  logic             r_pwm;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_duty_s <= '0;
      r_duty_a <= '0;
      r_pwm    <= 1'b0;
    end else begin
      if (load) r_duty_s <= duty;
      if (xfer) r_duty_a <= r_duty_s;
      r_pwm <= en & (cnt < r_duty_a);
    end
  end

  assign pwm_out = r_pwm;

endmodule

// File: rtl/pwm_multichannel.sv
// Multichannel PWM: shared prescaler, edge/center counter and shadow
// transfer control, driving NCH compare channels.
module pwm_multichannel
  import pwm_pkg::*;
#(
  parameter int NCH     = NCH_DEF,
  parameter int WIDTH   = WIDTH_DEF,
  parameter int PRESC_W = PRESC_W_DEF
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 en,
  input  logic                 mode,
  input  logic [PRESC_W-1:0]   presc,
  input  logic [WIDTH-1:0]     period,
  input  logic [NCH*WIDTH-1:0] duty,
  input  logic                 load,
  output logic [NCH-1:0]       pwm_out,
  output logic                 period_end,
  output logic                 pending
);

  logic [PRESC_W-1:0] r_psc;
  logic [WIDTH-1:0]   r_cnt;
  logic               r_dir_down;
  pwm_mode_e          r_mode_s;
  pwm_mode_e          r_mode_a;
  logic [WIDTH-1:0]   r_period_s;
  logic [WIDTH-1:0]   r_period_a;
  logic               r_pending;
  logic               r_period_end;

  logic               w_tick;
  logic               w_bound;
  logic               w_xfer;
  logic [WIDTH-1:0]   w_cnt_next;
  logic               w_dir_down_next;

  assign w_tick = en && (r_psc == presc);

  always_comb begin
    w_cnt_next      = r_cnt;
    w_dir_down_next = r_dir_down;
    w_bound         = 1'b0;
    if (w_tick) begin
      if (r_mode_a == PWM_EDGE) begin
        if (r_cnt >= r_period_a) begin
          w_cnt_next = '0;
          w_bound    = 1'b1;
        end else begin
          w_cnt_next = r_cnt + WIDTH'(1);
        end
      end else if (!r_dir_down) begin
        // At the top, periods 0 and 1 fall straight back to the bottom.
        if (r_cnt < r_period_a) begin
          w_cnt_next = r_cnt + WIDTH'(1);
        end else if (r_cnt <= WIDTH'(1)) begin
          w_cnt_next = '0;
          w_bound    = 1'b1;
        end else begin
          w_cnt_next      = r_cnt - WIDTH'(1);
          w_dir_down_next = 1'b1;
        end
      end else begin
        w_cnt_next = r_cnt - WIDTH'(1);
        if (r_cnt <= WIDTH'(1)) begin
          w_cnt_next      = '0;
          w_bound         = 1'b1;
          w_dir_down_next = 1'b0;
        end
      end
    end
  end

  // A coincident load defers the transfer; while stopped it happens at once.
  assign w_xfer = r_pending && !load && (en ? w_bound : 1'b1);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_psc        <= '0;
      r_cnt        <= '0;
      r_dir_down   <= 1'b0;
      r_mode_s     <= PWM_EDGE;
      r_mode_a     <= PWM_EDGE;
      r_period_s   <= '0;
      r_period_a   <= '0;
      r_pending    <= 1'b0;
      r_period_end <= 1'b0;
    end else begin
      if (!en) begin
        r_psc      <= '0;
        r_cnt      <= '0;
        r_dir_down <= 1'b0;
      end else begin
        r_psc      <= w_tick ? '0 : r_psc + PRESC_W'(1);
        r_cnt      <= w_cnt_next;
        r_dir_down <= w_dir_down_next;
      end
      r_period_end <= w_bound;
      if (load) begin
        r_mode_s   <= pwm_mode_e'(mode);
        r_period_s <= period;
        r_pending  <= 1'b1;
      end else if (w_xfer) begin
        r_pending  <= 1'b0;
      end
      if (w_xfer) begin
        r_mode_a   <= r_mode_s;
        r_period_a <= r_period_s;
      end
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < NCH; gi++) begin : g_chan
      pwm_chan #(
        .WIDTH(WIDTH)
      ) u_chan (
        .clk    (clk),
        .rst_n  (rst_n),
        .en     (en),
        .load   (load),
        .xfer   (w_xfer),
        .duty   (duty[gi*WIDTH +: WIDTH]),
        .cnt    (r_cnt),
        .pwm_out(pwm_out[gi])
      );
    end
  endgenerate

  assign period_end = r_period_end;
  assign pending    = r_pending;

endmodule

// File: tb/tb_pwm_multichannel.sv
// Self-checking bench for pwm_multichannel: per-cycle reference model plus
// directed scenarios with hand-computed window counts and patterns.
module tb_pwm_multichannel;

  localparam int NCH = 4;
  localparam int W   = 8;
  localparam int PW  = 4;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             en;
  logic             mode;
  logic [PW-1:0]    presc;
  logic [W-1:0]     period;
  logic [NCH*W-1:0] duty;
  logic             load;
  logic [NCH-1:0]   pwm_out;
  logic             period_end;
  logic             pending;

  pwm_multichannel #(.NCH(NCH), .WIDTH(W), .PRESC_W(PW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (en),
    .mode      (mode),
    .presc     (presc),
    .period    (period),
    .duty      (duty),
    .load      (load),
    .pwm_out   (pwm_out),
    .period_end(period_end),
    .pending   (pending)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  bit chk_on   = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: position within the period, from which the counter
  // value follows as a triangle (center) or ramp (edge).
  int             m_psc, m_pos;
  bit             m_mode_s, m_mode_a, m_pend;
  int             m_per_s, m_per_a;
  int             m_duty_s[NCH];
  int             m_duty_a[NCH];
  logic [NCH-1:0] exp_pwm  = '0;
  logic           exp_pe   = 1'b0;
  logic           exp_pend = 1'b0;

  always @(posedge clk) begin : model
    int len, c;
    bit tick, bnd, xf;
    if (!rst_n) begin
      m_psc = 0; m_pos = 0; m_mode_s = 0; m_mode_a = 0; m_pend = 0;
      m_per_s = 0; m_per_a = 0;
      for (int i = 0; i < NCH; i++) begin m_duty_s[i] = 0; m_duty_a[i] = 0; end
      exp_pwm = '0; exp_pe = 1'b0; exp_pend = 1'b0;
    end else begin
      if (m_mode_a) len = (m_per_a == 0) ? 1 : 2 * m_per_a;
      else          len = m_per_a + 1;
      if (m_mode_a && m_pos > m_per_a) c = 2 * m_per_a - m_pos;
      else                             c = m_pos;
      tick = en && (m_psc == int'(presc));
      bnd  = tick && (m_pos == len - 1);
      xf   = m_pend && !load && (en ? bnd : 1'b1);
      for (int i = 0; i < NCH; i++) exp_pwm[i] = en && (c < m_duty_a[i]);
      exp_pe = bnd;
      if (!en) begin m_psc = 0; m_pos = 0; end
      else if (tick) begin m_psc = 0; m_pos = bnd ? 0 : m_pos + 1; end
      else m_psc = m_psc + 1;
      if (xf) begin
        m_mode_a = m_mode_s; m_per_a = m_per_s;
        for (int i = 0; i < NCH; i++) m_duty_a[i] = m_duty_s[i];
      end
      if (load) begin
        m_mode_s = mode; m_per_s = int'(period); m_pend = 1'b1;
        for (int i = 0; i < NCH; i++) m_duty_s[i] = int'(duty[i*W +: W]);
      end else if (xf) begin
        m_pend = 1'b0;
      end
      exp_pend = m_pend;
    end
  end

  always @(negedge clk) begin
    if (chk_on) begin
      check("pwm_out", 32'(pwm_out), 32'(exp_pwm));
      check("period_end", 32'(period_end), 32'(exp_pe));
      check("pending", 32'(pending), 32'(exp_pend));
    end
  end

  int win_hi[NCH];
  int win_pe;

  task automatic step(input int n);
    repeat (n) begin @(posedge clk); #2; end
  endtask

  task automatic do_load(input bit m, input int p, input logic [NCH*W-1:0] d);
    mode = m; period = W'(p); duty = d; load = 1'b1;
    step(1);
    load = 1'b0;
    $display("load   : mode=%0d period=%0d duty=%h presc=%0d en=%0d", m, p, d, presc, en);
  endtask

  task automatic wait_xfer();
    int k = 0;
    do begin @(negedge clk); k++; end while (pending && k < 300);
    if (pending) check("xfer_timeout", 32'(pending), 32'd0);
  endtask

  task automatic wait_pe();
    int k = 0;
    do begin @(negedge clk); k++; end while (!period_end && k < 300);
    if (!period_end) check("pe_timeout", 32'(period_end), 32'd1);
  endtask

  task automatic count_pending(output int n, output logic pe_at_clear);
    n = 0;
    @(negedge clk);
    while (pending && n < 300) begin n++; @(negedge clk); end
    pe_at_clear = period_end;
  endtask

  task automatic window(input int n);
    for (int c = 0; c < NCH; c++) win_hi[c] = 0;
    win_pe = 0;
    repeat (n) begin
      @(negedge clk);
      for (int c = 0; c < NCH; c++) if (pwm_out[c]) win_hi[c]++;
      if (period_end) win_pe++;
    end
    $display("window : %0d clk hi=%0d/%0d/%0d/%0d pe=%0d", n,
             win_hi[0], win_hi[1], win_hi[2], win_hi[3], win_pe);
  endtask

  initial begin
    int          np;
    logic        pe_clr;
    logic [7:0]  pat_pwm, pat_pe;
    rst_n = 1'b0; en = 1'b0; mode = 1'b0; presc = '0; period = '0; duty = '0; load = 1'b0;
    @(posedge clk); #1;
    chk_on = 1'b1;
    step(2);
    @(negedge clk);
    check("reset_pwm", 32'(pwm_out), 32'd0);
    check("reset_pe", 32'(period_end), 32'd0);
    check("reset_pend", 32'(pending), 32'd0);
    rst_n = 1'b1;
    $display("reset  : released");

    // Edge mode, loaded while stopped so it transfers on the next clock.
    do_load(1'b0, 9, {8'd5, 8'd10, 8'd0, 8'd3});
    @(negedge clk);
    check("load_sets_pending", 32'(pending), 32'd1);
    wait_xfer();
    en = 1'b1;
    step(5);
    window(20);
    check("edge_hi0", 32'(win_hi[0]), 32'd6);
    check("edge_hi1_duty0", 32'(win_hi[1]), 32'd0);
    check("edge_hi2_over", 32'(win_hi[2]), 32'd20);
    check("edge_hi3", 32'(win_hi[3]), 32'd10);
    check("edge_pe", 32'(win_pe), 32'd2);

    // Mid-period load: old duty holds until the boundary five clocks later.
    wait_pe();
    step(4);
    do_load(1'b0, 9, {8'd5, 8'd10, 8'd0, 8'd7});
    count_pending(np, pe_clr);
    check("shadow_pend_len", 32'(np), 32'd5);
    check("shadow_pe_at_clear", 32'(pe_clr), 32'd1);
    window(20);
    check("shadow_hi0", 32'(win_hi[0]), 32'd14);

    // Load on the boundary clock: transfer deferred a whole period.
    wait_pe();
    step(9);
    do_load(1'b0, 9, {8'd5, 8'd10, 8'd0, 8'd2});
    count_pending(np, pe_clr);
    check("coincide_pend_len", 32'(np), 32'd10);
    check("coincide_pe_at_clear", 32'(pe_clr), 32'd1);
    window(20);
    check("coincide_hi0", 32'(win_hi[0]), 32'd4);

    // Center mode, period 4: counter 0,1,2,3,4,3,2,1.
    do_load(1'b1, 4, {8'd4, 8'd5, 8'd0, 8'd2});
    wait_xfer();
    wait_pe();
    pat_pwm = '0; pat_pe = '0;
    for (int j = 0; j < 8; j++) begin
      if (j > 0) @(negedge clk);
      pat_pwm[j] = pwm_out[0];
      pat_pe[j]  = period_end;
    end
    check("center_pattern", 32'(pat_pwm), 32'h07);
    check("center_pe_pattern", 32'(pat_pe), 32'h01);
    window(16);
    check("center_hi0", 32'(win_hi[0]), 32'd6);
    check("center_hi1", 32'(win_hi[1]), 32'd0);
    check("center_hi2", 32'(win_hi[2]), 32'd16);
    check("center_hi3", 32'(win_hi[3]), 32'd14);
    check("center_pe", 32'(win_pe), 32'd2);

    // Period 0: every tick is a boundary.
    do_load(1'b0, 0, {8'd0, 8'd1, 8'd0, 8'd1});
    wait_xfer();
    window(10);
    check("p0_hi0", 32'(win_hi[0]), 32'd10);
    check("p0_hi2", 32'(win_hi[2]), 32'd10);
    check("p0_hi3", 32'(win_hi[3]), 32'd0);
    check("p0_pe", 32'(win_pe), 32'd10);

    // Prescaler 3: one counter step per four clocks.
    presc = 4'd3;
    do_load(1'b0, 9, {8'd5, 8'd10, 8'd0, 8'd3});
    wait_xfer();
    window(80);
    check("presc_hi0", 32'(win_hi[0]), 32'd24);
    check("presc_pe", 32'(win_pe), 32'd2);

    // Enable dropped right where the output would go high.
    wait_pe();
    en = 1'b0;
    $display("enable : en=0");
    @(negedge clk);
    check("en_off_pwm", 32'(pwm_out), 32'd0);
    step(3);
    en = 1'b1;
    $display("enable : en=1");
    step(1);
    window(40);
    check("en_on_hi0", 32'(win_hi[0]), 32'd12);
    check("en_on_pe", 32'(win_pe), 32'd1);

    // Reset for one clock while a load is pending.
    do_load(1'b1, 5, {8'd9, 8'd9, 8'd9, 8'd8});
    @(negedge clk);
    check("rst_pre_pending", 32'(pending), 32'd1);
    rst_n = 1'b0;
    step(1);
    rst_n = 1'b1;
    $display("reset  : one clock pulse");
    @(negedge clk);
    check("rst_pwm", 32'(pwm_out), 32'd0);
    check("rst_pe", 32'(period_end), 32'd0);
    check("rst_pending", 32'(pending), 32'd0);
    window(8);
    check("rst_hi0", 32'(win_hi[0]), 32'd0);
    check("rst_pe_rate", 32'(win_pe), 32'd2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
